serial_fifo_bridge: RTL and testbench
=====================================

# serial_fifo_bridge

Parametrised, buffered serial port between the processor's serial interface and an external byte link, replacing the processor's direct unbuffered serial connection. Holds a TX FIFO (processor → link) and an RX FIFO (link → processor), each `DEPTH` words of `DATA_W` bits, with ready/valid handshakes on the link side. It also provides occupancy counters and sticky error flags. The testbench's serial monitor attaches to the link TX side.

## Interface
- `DATA_W`, 8: word width, both directions.
- `DEPTH`, 16: entries per FIFO. Must be a power of two and ≥2. `AW = $clog2(DEPTH)`.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `cpu_tx_data`  in  DATA_W  word from processor.
- `cpu_tx_wren`  in  1  push strobe into TX FIFO.
- `cpu_tx_ready`  out  1  TX FIFO not full.
- `cpu_rx_data`  out  DATA_W  RX FIFO head (show-ahead); 0 when `cpu_rx_valid`=0.
- `cpu_rx_valid`  out  1  RX FIFO not empty.
- `cpu_rx_rden`  in  1  pop strobe from RX FIFO.
- `link_tx_data`  out  DATA_W  TX FIFO head; 0 when `link_tx_valid`=0.
- `link_tx_valid`  out  1  TX FIFO not empty.
- `link_tx_ready`  in  1  link accepts word.
- `link_rx_data`  in  DATA_W  word from link.
- `link_rx_valid`  in  1  link offers word.
- `link_rx_ready`  out  1  RX FIFO not full.
- `tx_count`  out  AW+1  TX occupancy, 0..DEPTH.
- `rx_count`  out  AW+1  RX occupancy, 0..DEPTH.
- `err`  out  2  sticky: bit0 TX overflow, bit1 RX underflow.

## Operation
- Both FIFOs use circular RAM with AW-bit read/write pointers that wrap modulo DEPTH, plus a registered count.
- Flags derive from registered count only, never from same-cycle pops.
  - full = (count == DEPTH); empty = (count == 0).
  - `cpu_tx_ready` = !tx_full; `link_rx_ready` = !rx_full.
  - `link_tx_valid` = !tx_empty; `cpu_rx_valid` = !rx_empty.
- TX push: `cpu_tx_wren` && !tx_full. TX pop: `link_tx_valid` && `link_tx_ready`.
- RX push: `link_rx_valid` && `link_rx_ready`. RX pop: `cpu_rx_rden` && !rx_empty.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full FIFO with push and pop in the same cycle: the push is rejected, because ready is low. On TX this also sets `err[0]`.
- `cpu_tx_wren` while tx_full: word dropped, `err[0]` set. Pointers and count are unchanged.
- `cpu_rx_rden` while rx_empty: ignored, `err[1]` set.
- Link side cannot overflow or underflow, because the handshake forbids it.
- `err` bits clear only on reset.
- Data ordering is strict FIFO per direction. There is no reordering, and the two directions are independent.

## Timing
- Reset (sampled at a rising edge) sets:
  - all pointers and counts to 0, and `err`=0;
  - `cpu_tx_ready`=1, `link_rx_ready`=1;
  - `cpu_rx_valid`=0, `link_tx_valid`=0;
  - data outputs=0.
- RAM contents are not reset.
- Reset asserted mid-transfer discards all buffered words at that edge.
- Latency: a word pushed at edge N appears at the opposite head, with valid=1, in the cycle after edge N. The first-word fall-through latency is 1 cycle.
- Throughput: 1 word/cycle per direction sustained.
- Head data is combinational from the RAM at the read pointer, gated by valid. It updates in the cycle after a pop.
- Counts and flags update at the same edge as the pointer change.

## Configuration
- Macro: `SERIAL_FIFO_LOOPBACK_EN`.
- Defined: adds input port `loopback` (1 bit). When `loopback`=1:
  - TX head transfers directly into RX when tx non-empty && rx not full, 1 word/cycle, 1-cycle latency.
  - `link_tx_valid` and `link_rx_ready` are forced to 0, and link inputs are ignored.
  - Changing `loopback` takes effect at the next edge; words already buffered are kept.
- Undefined: no `loopback` port, no loopback logic, normal link behaviour only.

## Test plan
- **Reset:** hold `reset` 10 cycles, then release -> `cpu_tx_ready`=1, `link_rx_ready`=1, both valids=0, counts=0, `err`=0.
- **TX order:** DEPTH=16; push 0x48,0x69,0x0A with `link_tx_ready`=0, then raise ready -> `tx_count`=3, then `link_tx_data` emits 0x48,0x69,0x0A on consecutive cycles, `tx_count`→0.
- **TX full and overflow:** push 17 words 0x00..0x10 with `link_tx_ready`=0 -> `cpu_tx_ready`=0 after the 16th push, 0x10 dropped, `err[0]`=1. Drain -> 0x00..0x0F with pointer wrap-around, `err[0]` stays 1.
- **Simultaneous push/pop:** RX holding 4 words, `link_rx_valid` and `cpu_rx_rden` both high for 20 cycles -> `rx_count` stays 4, output order preserved. Then `cpu_rx_rden` on an empty RX -> `err[1]`=1.
- **Reset mid-operation:** TX holding 5 words with link streaming, pulse reset 1 cycle -> next cycle `tx_count`=0 and `link_tx_valid`=0, no stale word emitted.
- **Loopback (macro defined):** set `loopback`=1, push 0xA5,0x5A -> `link_tx_valid` stays 0, then `cpu_rx_data` yields 0xA5 then 0x5A, first valid 2 cycles after the first push.

Source files
------------

// File: rtl/serial_fifo_bridge_if.sv
// Handshake bundle between the processor serial port and the external byte link.
// master drives the processor/link inputs; slave is the bridge itself.
interface serial_fifo_bridge_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] cpu_tx_data;
  logic              cpu_tx_wren;
  logic              cpu_tx_ready;
  logic [DATA_W-1:0] cpu_rx_data;
  logic              cpu_rx_valid;
  logic              cpu_rx_rden;
  logic [DATA_W-1:0] link_tx_data;
  logic              link_tx_valid;
  logic              link_tx_ready;
  logic [DATA_W-1:0] link_rx_data;
  logic              link_rx_valid;
  logic              link_rx_ready;

  modport master (
    output cpu_tx_data,
    output cpu_tx_wren,
    output cpu_rx_rden,
    output link_tx_ready,
    output link_rx_data,
    output link_rx_valid,
    input  cpu_tx_ready,
    input  cpu_rx_data,
    input  cpu_rx_valid,
    input  link_tx_data,
    input  link_tx_valid,
    input  link_rx_ready
  );

  modport slave (
    input  cpu_tx_data,
    input  cpu_tx_wren,
    input  cpu_rx_rden,
    input  link_tx_ready,
    input  link_rx_data,
    input  link_rx_valid,
    output cpu_tx_ready,
    output cpu_rx_data,
    output cpu_rx_valid,
    output link_tx_data,
    output link_tx_valid,
    output link_rx_ready
  );
endinterface

// File: rtl/serial_fifo_bridge.sv
// Buffered serial bridge: TX and RX FIFOs between processor and byte link.
// Optional SERIAL_FIFO_LOOPBACK_EN adds a loopback input routing TX into RX.
module serial_fifo_bridge_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     rd_ptr_d;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clock) begin
    if (push && !reset) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

module serial_fifo_bridge #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef SERIAL_FIFO_LOOPBACK_EN
  input  logic                     loopback,
`endif
  serial_fifo_bridge_if.slave      bus,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [1:0]               err
);
  localparam int AW = $clog2(DEPTH);

  logic              tx_push;
  logic              tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_push;
  logic              rx_pop;
  logic [DATA_W-1:0] rx_wdata;
  logic [DATA_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              ltx_valid;
  logic              lrx_ready;
  logic [1:0]        err_q;
  logic [1:0]        err_d;

  serial_fifo_bridge_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_tx (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus.cpu_tx_data),
    .rdata (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  serial_fifo_bridge_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_rx (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_wdata),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

`ifdef SERIAL_FIFO_LOOPBACK_EN
  logic lb_xfer;

  // loopback starves the link side and moves TX head straight into RX
  always_comb begin
    lb_xfer   = loopback && !tx_empty && !rx_full;
    ltx_valid = !loopback && !tx_empty;
    lrx_ready = !loopback && !rx_full;
    tx_pop    = lb_xfer || (ltx_valid && bus.link_tx_ready);
    rx_push   = lb_xfer || (bus.link_rx_valid && lrx_ready);
    rx_wdata  = loopback ? tx_head : bus.link_rx_data;
  end
`else
  always_comb begin
    ltx_valid = !tx_empty;
    lrx_ready = !rx_full;
    tx_pop    = ltx_valid && bus.link_tx_ready;
    rx_push   = bus.link_rx_valid && lrx_ready;
    rx_wdata  = bus.link_rx_data;
  end
`endif

  always_comb begin
    tx_push = bus.cpu_tx_wren && !tx_full;
    rx_pop  = bus.cpu_rx_rden && !rx_empty;
    err_d   = err_q;
    if (bus.cpu_tx_wren && tx_full)  err_d[0] = 1'b1;
    if (bus.cpu_rx_rden && rx_empty) err_d[1] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign bus.cpu_tx_ready  = !tx_full;
  assign bus.link_rx_ready = lrx_ready;
  assign bus.link_tx_valid = ltx_valid;
  assign bus.cpu_rx_valid  = !rx_empty;
  assign bus.link_tx_data  = ltx_valid ? tx_head : '0;
  assign bus.cpu_rx_data   = !rx_empty ? rx_head : '0;
  assign err               = err_q;
endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Directed self-checking bench for serial_fifo_bridge (DEPTH=16, DATA_W=8).
// Loopback scenario runs only when SERIAL_FIFO_LOOPBACK_EN is defined.
module tb_serial_fifo_bridge;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] tx_count;
  logic [4:0] rx_count;
  logic [1:0] err;
  int         checks = 0;
  int         errors = 0;
`ifdef SERIAL_FIFO_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  serial_fifo_bridge_if #(.DATA_W(8)) bus ();

  serial_fifo_bridge #(
    .DATA_W (8),
    .DEPTH  (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef SERIAL_FIFO_LOOPBACK_EN
    .loopback (loopback),
`endif
    .bus      (bus.slave),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.cpu_tx_ready !== 1'b1) begin
      errors++; $display("FAIL rst_cpu_tx_ready got %b want 1", bus.cpu_tx_ready);
    end
    checks++;
    if (bus.link_rx_ready !== 1'b1) begin
      errors++; $display("FAIL rst_link_rx_ready got %b want 1", bus.link_rx_ready);
    end
    checks++;
    if (bus.link_tx_valid !== 1'b0 || bus.cpu_rx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valids got %b%b want 00", bus.link_tx_valid, bus.cpu_rx_valid);
    end
    checks++;
    if (tx_count !== 5'd0 || rx_count !== 5'd0) begin
      errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", tx_count, rx_count);
    end
    checks++;
    if (err !== 2'b00) begin
      errors++; $display("FAIL rst_err got %b want 00", err);
    end
    checks++;
    if (bus.link_tx_data !== 8'h00 || bus.cpu_rx_data !== 8'h00) begin
      errors++; $display("FAIL rst_data got %h/%h want 00/00", bus.link_tx_data, bus.cpu_rx_data);
    end
  endtask

  task automatic test_tx_order();
    logic [7:0] w [3];
    w[0] = 8'h48; w[1] = 8'h69; w[2] = 8'h0A;
    bus.link_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_tx_data = w[i];
      bus.cpu_tx_wren = 1'b1;
      tick();
      if (i == 0) begin
        checks++;
        if (bus.link_tx_valid !== 1'b1 || bus.link_tx_data !== 8'h48) begin
          errors++; $display("FAIL tx_first_latency got v=%b d=%h want v=1 d=48", bus.link_tx_valid, bus.link_tx_data);
        end
      end
    end
    bus.cpu_tx_wren = 1'b0;
    checks++;
    if (tx_count !== 5'd3) begin
      errors++; $display("FAIL tx_order_count got %0d want 3", tx_count);
    end
    bus.link_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.link_tx_valid !== 1'b1 || bus.link_tx_data !== w[i]) begin
        errors++; $display("FAIL tx_order_word%0d got v=%b d=%h want v=1 d=%h", i, bus.link_tx_valid, bus.link_tx_data, w[i]);
      end
      tick();
    end
    bus.link_tx_ready = 1'b0;
    checks++;
    if (tx_count !== 5'd0 || bus.link_tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_order_drained got cnt=%0d v=%b want 0/0", tx_count, bus.link_tx_valid);
    end
  endtask

  task automatic test_tx_overflow();
    bus.link_tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.cpu_tx_data = 8'(i);
      bus.cpu_tx_wren = 1'b1;
      tick();
      if (i == 14) begin
        checks++;
        if (bus.cpu_tx_ready !== 1'b1 || tx_count !== 5'd15) begin
          errors++; $display("FAIL ovf_at15 got rdy=%b cnt=%0d want 1/15", bus.cpu_tx_ready, tx_count);
        end
      end
      if (i == 15) begin
        checks++;
        if (bus.cpu_tx_ready !== 1'b0 || tx_count !== 5'd16 || err !== 2'b00) begin
          errors++; $display("FAIL ovf_full got rdy=%b cnt=%0d err=%b want 0/16/00", bus.cpu_tx_ready, tx_count, err);
        end
      end
    end
    bus.cpu_tx_wren = 1'b0;
    checks++;
    if (err !== 2'b01 || tx_count !== 5'd16) begin
      errors++; $display("FAIL ovf_err got err=%b cnt=%0d want 01/16", err, tx_count);
    end
    bus.link_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.link_tx_valid !== 1'b1 || bus.link_tx_data !== 8'(i)) begin
        errors++; $display("FAIL ovf_drain%0d got v=%b d=%h want v=1 d=%h", i, bus.link_tx_valid, bus.link_tx_data, 8'(i));
      end
      tick();
    end
    bus.link_tx_ready = 1'b0;
    checks++;
    if (tx_count !== 5'd0 || bus.link_tx_valid !== 1'b0 || err !== 2'b01) begin
      errors++; $display("FAIL ovf_end got cnt=%0d v=%b err=%b want 0/0/01", tx_count, bus.link_tx_valid, err);
    end
  endtask

  task automatic test_simul_rx();
    bus.cpu_rx_rden   = 1'b0;
    bus.link_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.link_rx_data = 8'h10 + 8'(i);
      tick();
    end
    checks++;
    if (rx_count !== 5'd4 || bus.cpu_rx_data !== 8'h10) begin
      errors++; $display("FAIL rx_fill got cnt=%0d d=%h want 4/10", rx_count, bus.cpu_rx_data);
    end
    bus.cpu_rx_rden = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.link_rx_data = 8'h14 + 8'(i);
      checks++;
      if (bus.cpu_rx_valid !== 1'b1 || bus.cpu_rx_data !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL rx_simul_word%0d got v=%b d=%h want v=1 d=%h", i, bus.cpu_rx_valid, bus.cpu_rx_data, 8'h10 + 8'(i));
      end
      tick();
      checks++;
      if (rx_count !== 5'd4) begin
        errors++; $display("FAIL rx_simul_count%0d got %0d want 4", i, rx_count);
      end
    end
    bus.link_rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.cpu_rx_data !== 8'h24 + 8'(i)) begin
        errors++; $display("FAIL rx_drain%0d got %h want %h", i, bus.cpu_rx_data, 8'h24 + 8'(i));
      end
      tick();
    end
    checks++;
    if (rx_count !== 5'd0 || bus.cpu_rx_valid !== 1'b0 || err !== 2'b01) begin
      errors++; $display("FAIL rx_empty got cnt=%0d v=%b err=%b want 0/0/01", rx_count, bus.cpu_rx_valid, err);
    end
    tick();
    bus.cpu_rx_rden = 1'b0;
    checks++;
    if (err !== 2'b11 || rx_count !== 5'd0 || bus.cpu_rx_data !== 8'h00) begin
      errors++; $display("FAIL rx_underflow got err=%b cnt=%0d d=%h want 11/0/00", err, rx_count, bus.cpu_rx_data);
    end
  endtask

  task automatic test_reset_mid();
    bus.link_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.cpu_tx_data = 8'hC0 + 8'(i);
      bus.cpu_tx_wren = 1'b1;
      tick();
    end
    bus.cpu_tx_wren = 1'b0;
    bus.link_tx_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (tx_count !== 5'd3 || bus.link_tx_data !== 8'hC2) begin
      errors++; $display("FAIL midrst_pre got cnt=%0d d=%h want 3/c2", tx_count, bus.link_tx_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (tx_count !== 5'd0 || bus.link_tx_valid !== 1'b0 || bus.link_tx_data !== 8'h00) begin
      errors++; $display("FAIL midrst_post got cnt=%0d v=%b d=%h want 0/0/00", tx_count, bus.link_tx_valid, bus.link_tx_data);
    end
    checks++;
    if (err !== 2'b00) begin
      errors++; $display("FAIL midrst_err got %b want 00", err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.link_tx_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_stale%0d got v=%b d=%h want v=0", i, bus.link_tx_valid, bus.link_tx_data);
      end
    end
    bus.link_tx_ready = 1'b0;
  endtask

`ifdef SERIAL_FIFO_LOOPBACK_EN
  task automatic test_loopback();
    loopback          = 1'b1;
    bus.link_tx_ready = 1'b1;
    bus.link_rx_valid = 1'b1;
    bus.link_rx_data  = 8'hEE;
    tick();
    checks++;
    if (bus.link_rx_ready !== 1'b0 || rx_count !== 5'd0) begin
      errors++; $display("FAIL lb_link_ignored got rdy=%b cnt=%0d want 0/0", bus.link_rx_ready, rx_count);
    end
    bus.cpu_tx_data = 8'hA5;
    bus.cpu_tx_wren = 1'b1;
    tick();
    bus.cpu_tx_data = 8'h5A;
    checks++;
    if (bus.cpu_rx_valid !== 1'b0 || bus.link_tx_valid !== 1'b0) begin
      errors++; $display("FAIL lb_cycle1 got rxv=%b ltv=%b want 0/0", bus.cpu_rx_valid, bus.link_tx_valid);
    end
    tick();
    bus.cpu_tx_wren = 1'b0;
    checks++;
    if (bus.cpu_rx_valid !== 1'b1 || bus.cpu_rx_data !== 8'hA5 || bus.link_tx_valid !== 1'b0) begin
      errors++; $display("FAIL lb_first got v=%b d=%h ltv=%b want 1/a5/0", bus.cpu_rx_valid, bus.cpu_rx_data, bus.link_tx_valid);
    end
    bus.cpu_rx_rden = 1'b1;
    tick();
    checks++;
    if (bus.cpu_rx_valid !== 1'b1 || bus.cpu_rx_data !== 8'h5A || bus.link_tx_valid !== 1'b0) begin
      errors++; $display("FAIL lb_second got v=%b d=%h ltv=%b want 1/5a/0", bus.cpu_rx_valid, bus.cpu_rx_data, bus.link_tx_valid);
    end
    tick();
    bus.cpu_rx_rden = 1'b0;
    checks++;
    if (bus.cpu_rx_valid !== 1'b0 || tx_count !== 5'd0 || rx_count !== 5'd0) begin
      errors++; $display("FAIL lb_end got v=%b tx=%0d rx=%0d want 0/0/0", bus.cpu_rx_valid, tx_count, rx_count);
    end
    bus.link_rx_valid = 1'b0;
    loopback          = 1'b0;
    bus.link_tx_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.cpu_tx_data   = '0;
    bus.cpu_tx_wren   = 1'b0;
    bus.cpu_rx_rden   = 1'b0;
    bus.link_tx_ready = 1'b0;
    bus.link_rx_data  = '0;
    bus.link_rx_valid = 1'b0;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_simul_rx();
    test_reset_mid();
`ifdef SERIAL_FIFO_LOOPBACK_EN
    test_loopback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
